// File: rtl/chip_draw_ctrl.sv
// Command front end for the 16x16 chip sprite drawer. It queues board placements,
// converts them to a pixel origin, strobes the drawer for 256 cycles and aligns plot.
module chip_draw_ctrl #(
   parameter int X0       = 24,
   parameter int Y0       = 8,
   parameter int COLS     = 7,
   parameter int ROWS     = 6,
   parameter int PLOT_LAG = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_col,
   input  logic [2:0] cmd_row,
   input  logic       cmd_player,
   output logic [7:0] xin,
   output logic [6:0] yin,
   output logic       drawr,
   output logic       drawb,
   output logic       en_cycle,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAW  = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic       player;
      logic [2:0] row;
      logic [2:0] col;
   } cmd_t;

   localparam logic [7:0] X0_L       = 8'(X0);
   localparam logic [6:0] Y0_L       = 7'(Y0);
   localparam logic [3:0] COLS_L     = 4'(COLS);
   localparam logic [3:0] ROWS_L     = 4'(ROWS);
   localparam logic [8:0] DRAW_LAST  = 9'd255;
   localparam logic [8:0] FLUSH_LAST = 9'(PLOT_LAG - 1);

   state_t state_q, state_d;
   logic [8:0] cnt_q, cnt_d;

   cmd_t       fifo_q [2];
   cmd_t       cur_q;
   logic       wr_ptr_q, rd_ptr_q;
   logic [1:0] count_q;

   logic [7:0] xin_q;
   logic [6:0] yin_q;
   logic drawr_q, drawb_q, en_cycle_q, busy_q, done_q, err_q;
   logic drawr_d, drawb_d, en_cycle_d, busy_d, done_d;
   logic [PLOT_LAG-1:0] plot_pipe_q;

   logic full_s, accept_s, legal_s, push_s, pop_s;
   cmd_t cmd_in_s;

   assign full_s    = (count_q == 2'd2);
   assign cmd_ready = ~full_s & ~reset;
   assign accept_s  = cmd_valid & cmd_ready;
   assign legal_s   = ({1'b0, cmd_col} < COLS_L) && ({1'b0, cmd_row} < ROWS_L);
   assign push_s    = accept_s & legal_s;
   assign pop_s     = (state_q == S_IDLE) && (count_q != 2'd0);
   assign cmd_in_s  = '{player: cmd_player, row: cmd_row, col: cmd_col};

   // Two-entry in-order queue; the popped head is held in cur_q for the whole command.
   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_q[0] <= cmd_t'(7'd0);
         fifo_q[1] <= cmd_t'(7'd0);
         cur_q     <= cmd_t'(7'd0);
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push_s) begin
            fifo_q[wr_ptr_q] <= cmd_in_s;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_s) begin
            cur_q    <= fifo_q[rd_ptr_q];
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // State and shared DRAW/FLUSH counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 9'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the counter restarts on each phase entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pop_s) state_d = S_LOAD;
            else       state_d = S_IDLE;
         end
         S_LOAD: begin
            state_d = S_DRAW;
            cnt_d   = 9'd0;
         end
         S_DRAW: begin
            if (cnt_q == DRAW_LAST) begin
               state_d = S_FLUSH;
               cnt_d   = 9'd0;
            end else begin
               cnt_d   = cnt_q + 9'd1;
            end
         end
         S_FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = S_DONE;
               cnt_d   = 9'd0;
            end else begin
               cnt_d   = cnt_q + 9'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: begin
            state_d = S_IDLE;
            cnt_d   = 9'd0;
         end
      endcase
   end

   // Outputs decoded from the next state so that the registered strobes line up with it.
   always_comb begin
      drawr_d    = 1'b0;
      drawb_d    = 1'b0;
      en_cycle_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      case (state_d)
         S_LOAD:  busy_d = 1'b1;
         S_DRAW: begin
            busy_d     = 1'b1;
            en_cycle_d = 1'b1;
            if (cur_q.player) drawb_d = 1'b1;
            else              drawr_d = 1'b1;
         end
         S_FLUSH: busy_d = 1'b1;
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: busy_d = 1'b0;
      endcase
   end

   // Output registers; origin is loaded once per command and held until the next LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         xin_q      <= 8'd0;
         yin_q      <= 7'd0;
         drawr_q    <= 1'b0;
         drawb_q    <= 1'b0;
         en_cycle_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == S_LOAD) begin
            xin_q <= X0_L + {1'b0, cur_q.col, 4'd0};
            yin_q <= Y0_L + {cur_q.row, 4'd0};
         end
         drawr_q    <= drawr_d;
         drawb_q    <= drawb_d;
         en_cycle_q <= en_cycle_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= accept_s & ~legal_s;
      end
   end

   // Plot delay line matching the drawer's colour latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         plot_pipe_q <= {PLOT_LAG{1'b0}};
      end else begin
         plot_pipe_q[0] <= drawr_q | drawb_q;
         for (int i = 1; i < PLOT_LAG; i++) begin
            plot_pipe_q[i] <= plot_pipe_q[i-1];
         end
      end
   end

   assign xin      = xin_q;
   assign yin      = yin_q;
   assign drawr    = drawr_q;
   assign drawb    = drawb_q;
   assign en_cycle = en_cycle_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign plot     = plot_pipe_q[PLOT_LAG-1];

endmodule
